// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Pixel-timing generator for the 640x480 @ 60 Hz display path. Holds the
// horizontal and vertical position counters and turns them into registered
// sync, blanking, position and frame-start outputs.
//
// Optional build macro: VGA_CLK_DIV2_EN
//   undefined : every clk edge is a pixel tick (clk = 25 MHz pixel clock).
//   defined   : an internal toggle flop enables every second clk edge, so a
//               50 MHz clk produces the same 25 MHz timing. Every output value
//               then persists for two clk cycles.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active low
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   blank_n     out  1 = visible pixel, 0 = blanking
//   row         out  visible line index 0..V_ACTIVE-1, 0 while blanked
//   column      out  visible pixel index 0..H_ACTIVE-1, 0 while blanked
//   frame_start out  one-tick pulse presenting the first pixel of a frame
//
// All outputs are registered decodes of the counter values before the
// increment, so they trail the counters by exactly one pixel tick. The first
// tick after reset release therefore presents pixel (0,0).
// Totals must fit the 10-bit counters (<= 1024) and V_ACTIVE must be <= 512.
// -----------------------------------------------------------------------------
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic [8:0] row,
    output logic [9:0] column,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Compare in 11 bits so a sync end or total of exactly 1024 still fits.
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        tick;
    logic        h_wrap;
    logic        v_wrap;
    logic        active;
    logic        h_sync_zone;
    logic        v_sync_zone;

`ifdef VGA_CLK_DIV2_EN
    // Toggle flop: tick is high on every second clk edge, starting with the
    // second edge after reset release.
    logic div_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
        end
    end

    assign tick = div_q;
`else
    assign tick = 1'b1;
`endif

    assign h_ext  = {1'b0, h_cnt};
    assign v_ext  = {1'b0, v_cnt};
    assign h_wrap = (h_ext == H_LAST);
    assign v_wrap = (v_ext == V_LAST);
    assign active = (h_ext < H_ACT) && (v_ext < V_ACT);

    assign h_sync_zone = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    // vsync covers whole lines: it depends on v_cnt only.
    assign v_sync_zone = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            row         <= '0;
            column      <= '0;
            frame_start <= 1'b0;
        end else if (tick) begin
            // Position counters: h wraps every line, v advances on that wrap.
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end

            // Both indices are forced to zero on every blanked tick (horizontal
            // and vertical blanking alike) so the color stage never sees a
            // stale coordinate.
            blank_n     <= active;
            column      <= active ? h_cnt : '0;
            row         <= active ? v_cnt[8:0] : '0;
            hsync       <= ~h_sync_zone;
            vsync       <= ~v_sync_zone;
            frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//
// Bench for vga_timing. Two instances share clock and reset: one with the
// default 640x480 timing (used for line-level measurements) and one with a
// small 17x13 raster (frame = 221 ticks) so whole frames, vsync and the frame
// period can be observed within a short run.
//
// Every clk edge the driver pushes the expected output word of both instances
// into exp_q; a monitor on the falling edge pops and compares. Directed checks
// on top of that compare hand-computed edge positions (hsync fall 657 ticks
// after release, width 96, line 800, small frame 221, ...). All edge positions
// scale by DIV, which is 2 when VGA_CLK_DIV2_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing;

`ifdef VGA_CLK_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // Small raster: H 10+2+3+2 = 17, V 6+2+2+3 = 13, frame 221 ticks.
    localparam int SH_A = 10, SH_F = 2, SH_S = 3, SH_B = 2;
    localparam int SV_A = 6,  SV_F = 2, SV_S = 2, SV_B = 3;
    localparam int SH_T = SH_A + SH_F + SH_S + SH_B;
    localparam int SV_T = SV_A + SV_F + SV_S + SV_B;

    // {hsync, vsync, blank_n, row[8:0], column[9:0], frame_start}
    localparam logic [22:0] RST_WORD = {1'b1, 1'b1, 1'b0, 9'd0, 10'd0, 1'b0};

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic       b_hsync, b_vsync, b_blank_n, b_frame_start;
    logic [8:0] b_row;
    logic [9:0] b_column;
    logic       s_hsync, s_vsync, s_blank_n, s_frame_start;
    logic [8:0] s_row;
    logic [9:0] s_column;
    logic [22:0] b_word;
    logic [22:0] s_word;

    assign b_word = {b_hsync, b_vsync, b_blank_n, b_row, b_column, b_frame_start};
    assign s_word = {s_hsync, s_vsync, s_blank_n, s_row, s_column, s_frame_start};

    vga_timing u_big (
        .clk         (clk),
        .rst         (rst),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .blank_n     (b_blank_n),
        .row         (b_row),
        .column      (b_column),
        .frame_start (b_frame_start)
    );

    vga_timing #(
        .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
        .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B)
    ) u_small (
        .clk         (clk),
        .rst         (rst),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .blank_n     (s_blank_n),
        .row         (s_row),
        .column      (s_column),
        .frame_start (s_frame_start)
    );

    // ---------------- scoreboard state ----------------
    logic [45:0] exp_q[$];
    logic [45:0] last_exp;
    logic [45:0] mon_w;
    int          n_checks;
    int          n_pass;
    int          mh, mv, sh, sv;
    bit          tog;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [22:0] decode(input int h, input int v,
                                           input int ha, input int hf, input int hs,
                                           input int va, input int vf, input int vs);
        logic       act;
        logic [8:0] r;
        logic [9:0] c;
        act = (h < ha) && (v < va);
        r   = act ? 9'(v) : 9'd0;
        c   = act ? 10'(h) : 10'd0;
        return {!((h >= ha + hf) && (h < ha + hf + hs)),
                !((v >= va + vf) && (v < va + vf + vs)),
                act, r, c, (h == 0) && (v == 0)};
    endfunction

    // ---------------- driver tasks ----------------
    // One clk edge: compute what both DUTs must show after it and queue it.
    task automatic step();
        logic [45:0] w;
        @(posedge clk);
        if (!rst) begin
            mh = 0; mv = 0; sh = 0; sv = 0; tog = 1'b0;
            w = {RST_WORD, RST_WORD};
        end else if (DIV == 1 || tog) begin
            w = {decode(mh, mv, 640, 16, 96, 480, 10, 2),
                 decode(sh, sv, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S)};
            mh++;
            if (mh == 800) begin
                mh = 0; mv++;
                if (mv == 525) mv = 0;
            end
            sh++;
            if (sh == SH_T) begin
                sh = 0; sv++;
                if (sv == SV_T) sv = 0;
            end
            tog = ~tog;
        end else begin
            w = last_exp;
            tog = ~tog;
        end
        exp_q.push_back(w);
        last_exp = w;
    endtask

    // Reset changes just after a falling edge, clear of both compare points.
    task automatic set_rst(input logic val);
        @(negedge clk);
        #1 rst = val;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_w = exp_q.pop_front();
            chk("big_outputs", 32'(b_word), 32'(mon_w[45:23]));
            chk("small_outputs", 32'(s_word), 32'(mon_w[22:0]));
        end
    end

    // ---------------- stimulus + directed checks ----------------
    initial begin
        int   fall1, rise1, fall2, bfall;
        int   sfs1, sfs2, sfs_cnt, svfall, svrise, srow_max;
        logic prev_bh, prev_bb, prev_sfs, prev_sv;
        bit   found;

        n_checks = 0;
        n_pass   = 0;
        mh = 0; mv = 0; sh = 0; sv = 0; tog = 1'b0;
        last_exp = {RST_WORD, RST_WORD};
        rst = 1'b0;

        // Reset held for 5 clocks.
        repeat (5) step();
        #1;
        chk("reset_hold_big", 32'(b_word), 32'(RST_WORD));
        chk("reset_hold_small", 32'(s_word), 32'(RST_WORD));

        set_rst(1'b1);

        fall1 = -1; rise1 = -1; fall2 = -1; bfall = -1;
        sfs1 = -1; sfs2 = -1; sfs_cnt = 0; svfall = -1; svrise = -1; srow_max = 0;
        prev_bh = 1'b1; prev_bb = 1'b0; prev_sfs = 1'b0; prev_sv = 1'b1;

        // e counts clk edges after release; pixel tick t appears at e = DIV*(t+1).
        for (int e = 1; e <= DIV * 1500; e++) begin
            step();
            #1;
            if (e == DIV)
                chk("first_pixel", 32'(b_word), 32'({1'b1, 1'b1, 1'b1, 9'd0, 10'd0, 1'b1}));
            if (e == 2 * DIV - 1)
                chk("fs_held", 32'(b_frame_start), 32'(1));
            if (e == 2 * DIV)
                chk("fs_drop", 32'(b_frame_start), 32'(0));
            if (e == DIV * 640)
                chk("col_639", 32'({b_blank_n, b_column}), 32'({1'b1, 10'd639}));
            if (e == DIV * 641)
                chk("col_640_blank", 32'({b_blank_n, b_column}), 32'({1'b0, 10'd0}));

            if (prev_bh && !b_hsync) begin
                if (fall1 < 0) fall1 = e;
                else if (fall2 < 0) fall2 = e;
            end
            if (!prev_bh && b_hsync && rise1 < 0) rise1 = e;
            if (prev_bb && !b_blank_n && bfall < 0) bfall = e;
            if (!prev_sfs && s_frame_start) begin
                sfs_cnt++;
                if (sfs1 < 0) sfs1 = e;
                else if (sfs2 < 0) sfs2 = e;
            end
            if (prev_sv && !s_vsync && svfall < 0) svfall = e;
            if (!prev_sv && s_vsync && svfall >= 0 && svrise < 0) svrise = e;
            if (s_blank_n && int'(s_row) > srow_max) srow_max = int'(s_row);

            prev_bh  = b_hsync;
            prev_bb  = b_blank_n;
            prev_sfs = s_frame_start;
            prev_sv  = s_vsync;
        end

        chk("hsync_fall", 32'(fall1), 32'(DIV * 657));
        chk("hsync_width", 32'(rise1 - fall1), 32'(DIV * 96));
        chk("line_period", 32'(fall2 - fall1), 32'(DIV * 800));
        chk("blank_fall", 32'(bfall), 32'(DIV * 641));
        chk("small_fs_first", 32'(sfs1), 32'(DIV));
        chk("small_frame_period", 32'(sfs2 - sfs1), 32'(DIV * 221));
        chk("small_fs_count", 32'(sfs_cnt), 32'(7));
        chk("small_vsync_fall", 32'(svfall), 32'(DIV * 137));
        chk("small_vsync_width", 32'(svrise - svfall), 32'(DIV * 34));
        chk("small_last_row", 32'(srow_max), 32'(5));

        // Mid-frame reset: stop on small-raster pixel (row 4, column 5).
        found = 1'b0;
        for (int i = 0; i < DIV * 600 && !found; i++) begin
            step();
            #1;
            if (s_blank_n && s_row == 9'd4 && s_column == 10'd5) found = 1'b1;
        end
        chk("reset_point_found", 32'(found), 32'(1));

        set_rst(1'b0);
        #1;
        chk("async_reset_big", 32'(b_word), 32'(RST_WORD));
        chk("async_reset_small", 32'(s_word), 32'(RST_WORD));
        repeat (3) step();
        set_rst(1'b1);

        sfs1 = -1; sfs2 = -1; prev_sfs = 1'b0;
        for (int e = 1; e <= DIV * 230; e++) begin
            step();
            #1;
            if (e == DIV)
                chk("restart_first_pixel", 32'(b_word),
                    32'({1'b1, 1'b1, 1'b1, 9'd0, 10'd0, 1'b1}));
            if (!prev_sfs && s_frame_start) begin
                if (sfs1 < 0) sfs1 = e;
                else if (sfs2 < 0) sfs2 = e;
            end
            prev_sfs = s_frame_start;
        end
        chk("restart_fs_first", 32'(sfs1), 32'(DIV));
        chk("restart_frame_period", 32'(sfs2 - sfs1), 32'(DIV * 221));

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Pixel-timing generator for the 640x480 @ 60 Hz display path.
- Produces the hsync/vsync pulses for the DAC/connector.
- Produces the blank_n/row/column triple that the downstream color stage consumes to choose pixel RGB.
- Contains the horizontal and vertical counters, sync decode, and a frame-start strobe used by game logic to update state between frames.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  input  1  system clock; 25 MHz pixel clock, or 50 MHz when VGA_CLK_DIV2_EN is defined
- rst  input  1  asynchronous, active-low reset
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- blank_n  output  1  1 = visible pixel, 0 = blanking
- row  output  9  visible line index 0..479, 0 outside the active area
- column  output  10  visible pixel index 0..639, 0 outside the active area
- frame_start  output  1  one-tick pulse at the first pixel of each frame

Behaviour:
- Pixel tick:
  - Without the macro: every clk edge.
  - With the macro: see Optional Feature.
  - All state updates occur only on pixel ticks; between ticks, everything holds.
- Counter lengths:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters:
  - h_cnt and v_cnt are 10-bit. Parameter sets must give totals ≤ 1024 and V_ACTIVE ≤ 512.
  - h_cnt increments each tick and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - The simultaneous wrap of both (799,524) -> (0,0) is the frame boundary.
- Reset (rst low, asynchronous, held while low):
  - h_cnt = 0, v_cnt = 0.
  - hsync = 1, vsync = 1, blank_n = 0, row = 0, column = 0, frame_start = 0.
- Outputs are registered decodes of the pre-increment counter values. On each tick:
  - blank_n <= (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - column <= h_cnt when h_cnt < H_ACTIVE, else 0.
  - row <= v_cnt[8:0] when v_cnt < V_ACTIVE, else 0.
  - hsync <= 0 iff H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync <= 0 iff V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for every h_cnt of those lines.
  - frame_start <= (h_cnt == 0 && v_cnt == 0); it is high for exactly one tick.
- Latency and release from reset:
  - Outputs lag the counters by one tick.
  - The first tick after reset release presents pixel (0,0): blank_n = 1, frame_start = 1, row = 0, column = 0.
- Period:
  - 800 ticks per line, 420000 ticks per frame.
  - Exactly one frame_start per frame.
- Reset mid-frame: counters and outputs return immediately to reset values. The next frame restarts at (0,0) with no partial-line artefacts beyond the truncated frame.
- Blanking: the downstream color stage depends on row = 0, column = 0 and blank_n = 0 during all blanking ticks.

Optional Feature:
- Macro: VGA_CLK_DIV2_EN.
- When defined:
  - An internal toggle flop (reset to 0) generates the pixel tick on every second clk edge, so a 50 MHz clk yields 25 MHz timing.
  - The tick is asserted when the toggle is 1.
  - Outputs change only on tick edges; each output value, including frame_start, persists for 2 clk cycles.
  - Frame = 840000 clk cycles.
  - The first output update after reset release happens on the 2nd clk edge.
- When undefined: no toggle flop; tick = every clk edge.

Test Plan:
- Reset: hold rst=0 for 5 clk -> hsync=1, vsync=1, blank_n=0, row=0, column=0, frame_start=0. Release -> next edge shows blank_n=1, frame_start=1, row=0, column=0; frame_start is 0 on the following edge.
- Active/blank boundary: step 640 ticks from frame start -> column counts 0..639 with blank_n=1, then blank_n=0 and column=0 at tick 640.
- Hsync: measure on line 0 -> hsync falls 656 ticks after line start, stays low exactly 96 ticks, line period 800 ticks.
- Vertical: count lines -> row = 479 on the last visible line, then blank_n=0 for lines 480..524. vsync is low for exactly 1600 ticks starting at line 490. frame_start recurs every 420000 ticks.
- Mid-frame reset: assert rst at line 300, column 123 for 3 clk -> outputs go to reset values asynchronously. After release, frame_start fires on the first edge and the next frame_start comes 420000 ticks later.
- VGA_CLK_DIV2_EN defined: rerun the reset and period checks -> every output transition is 2 clk apart, frame_start is high for 2 clk, frame period is 840000 clk.
